// File: rtl/hsr_noc_pkg.sv
// hsr_noc_pkg: shared HSR NoC direction codes, flit widths and target decode.
package hsr_noc_pkg;
  localparam int FLIT_W = 20;
  localparam int TAG_W = 3;
  localparam int N_PORT = 5;
  localparam logic [TAG_W-1:0] DIR_CW = 3'd1;
  localparam logic [TAG_W-1:0] DIR_CCW = 3'd2;
  localparam logic [TAG_W-1:0] DIR_UP = 3'd3;
  localparam logic [TAG_W-1:0] DIR_DOWN = 3'd4;
  localparam logic [TAG_W-1:0] DIR_PE = 3'd5;
  function automatic logic tgt_ok(input logic [TAG_W-1:0] t);
    return t >= DIR_CW && t <= DIR_PE;
  endfunction
  function automatic logic [2:0] tgt_idx(input logic [TAG_W-1:0] t);
    return t - DIR_CW;
  endfunction
endpackage

// File: rtl/hsr_rr_arbiter.sv
// hsr_rr_arbiter: 5-way round-robin arbiter with internally registered pointer.
module hsr_rr_arbiter
  import hsr_noc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [N_PORT-1:0] req,
  output logic [N_PORT-1:0] gnt
);
  logic [2:0] ptr, w;
  // Descending scan so the requester nearest to ptr is written last and wins.
  always_comb begin
    w = ptr;
    for (int k = N_PORT - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N_PORT]) w = 3'((int'(ptr) + k) % N_PORT);
    gnt = (en && |req) ? N_PORT'(1) << w : '0;
  end
  always_ff @(posedge clk)
    if (rst) ptr <= '0;
    else if (en && |req) ptr <= (w == 3'(N_PORT - 1)) ? 3'd0 : w + 3'd1;
endmodule

// File: rtl/hsr_switch_allocator.sv
// hsr_switch_allocator: per-output round-robin switch allocation into one-deep output buffers.
// Define HSR_SA_STATS_EN to add the saturating drop_count port.
module hsr_switch_allocator #(
  parameter int N_PORT = 5,
  parameter int DATA_W = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_PORT*(DATA_W+3)-1:0] in_flit,
  input  logic [N_PORT-1:0]          in_valid,
  output logic [N_PORT-1:0]          in_ready,
  output logic [N_PORT*DATA_W-1:0]   out_data,
  output logic [N_PORT-1:0]          out_valid,
  input  logic [N_PORT-1:0]          out_ready,
  output logic                       drop_pulse
`ifdef HSR_SA_STATS_EN
  ,
  output logic [15:0]                drop_count
`endif
);
  import hsr_noc_pkg::*;
  localparam int FW = DATA_W + TAG_W;
  logic [TAG_W-1:0] tgt [N_PORT];
  logic [N_PORT-1:0] req [N_PORT];
  logic [N_PORT-1:0] gnt [N_PORT];
  logic [DATA_W-1:0] wdata [N_PORT];
  logic [N_PORT-1:0] drop, grantable;
  assign grantable = ~out_valid | out_ready;
  assign drop_pulse = |drop;
  always_comb begin
    for (int i = 0; i < N_PORT; i++) begin
      tgt[i] = in_flit[i*FW +: TAG_W];
      drop[i] = !rst && in_valid[i] && !tgt_ok(tgt[i]);
    end
    for (int o = 0; o < N_PORT; o++)
      for (int i = 0; i < N_PORT; i++)
        req[o][i] = !rst && in_valid[i] && tgt_ok(tgt[i]) && tgt_idx(tgt[i]) == 3'(o);
  end
  always_comb begin
    in_ready = drop;
    for (int o = 0; o < N_PORT; o++) begin
      in_ready = in_ready | gnt[o];
      wdata[o] = '0;
      for (int i = 0; i < N_PORT; i++)
        if (gnt[o][i]) wdata[o] = in_flit[i*FW+TAG_W +: DATA_W];
    end
  end
  for (genvar o = 0; o < N_PORT; o++) begin : g_arb
    hsr_rr_arbiter u_arb (
      .clk (clk),
      .rst (rst),
      .en  (grantable[o]),
      .req (req[o]),
      .gnt (gnt[o])
    );
  end
  // A grant while draining reloads the buffer, so the old flit counts as delivered.
  always_ff @(posedge clk)
    if (rst) begin
      out_valid <= '0;
      out_data <= '0;
    end else begin
      for (int o = 0; o < N_PORT; o++)
        if (|gnt[o]) begin
          out_data[o*DATA_W +: DATA_W] <= wdata[o];
          out_valid[o] <= 1'b1;
        end else if (out_ready[o]) begin
          out_valid[o] <= 1'b0;
        end
    end
`ifdef HSR_SA_STATS_EN
  logic [16:0] sum;
  assign sum = {1'b0, drop_count} + 17'($countones(drop));
  always_ff @(posedge clk)
    if (rst) drop_count <= '0;
    else drop_count <= sum[16] ? 16'hFFFF : sum[15:0];
`endif
endmodule

// File: tb/tb_hsr_switch_allocator.sv
// tb_hsr_switch_allocator: directed scoreboard bench for hsr_switch_allocator.
module tb_hsr_switch_allocator;
  localparam int NP = 5;
  localparam int DW = 20;
  logic clk = 1'b0;
  logic rst;
  logic [NP*(DW+3)-1:0] in_flit;
  logic [NP-1:0] in_valid, in_ready, out_valid, out_ready;
  logic [NP*DW-1:0] out_data;
  logic drop_pulse;
`ifdef HSR_SA_STATS_EN
  logic [15:0] drop_count;
`endif
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] q [NP][$];

  hsr_switch_allocator dut (
    .clk        (clk),
    .rst        (rst),
    .in_flit    (in_flit),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .drop_pulse (drop_pulse)
`ifdef HSR_SA_STATS_EN
    ,
    .drop_count (drop_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int i, input logic [DW-1:0] d, input logic [2:0] t);
    in_flit[i*(DW+3) +: DW+3] = {d, t};
    in_valid[i] = 1'b1;
  endtask

  function automatic logic [DW-1:0] od(input int o);
    return out_data[o*DW +: DW];
  endfunction

  // Scoreboard: every flit leaving an output must be the oldest one expected there.
  always @(negedge clk)
    if (!rst)
      for (int o = 0; o < NP; o++) begin
        if (out_valid[o] && q[o].size() == 0) chk($sformatf("spurious_valid%0d", o), 32'(out_valid[o]), 32'd0);
        else if (out_valid[o] && out_ready[o]) chk($sformatf("deliver%0d", o), 32'(od(o)), 32'(q[o].pop_front()));
      end

  initial begin
    rst = 1'b1;
    in_flit = '0;
    in_valid = '0;
    out_ready = '0;
    put(1, 20'h00001, 3'd0);
    repeat (2) tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_drop_pulse", 32'(drop_pulse), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data == '0), 32'd1);
    in_valid = '0;
    rst = 1'b0;
    tick();
    // single flit to PE
    out_ready = '1;
    put(0, 20'hABCD4, 3'd5);
    #1;
    chk("t1_in_ready", 32'(in_ready), 32'h01);
    q[4].push_back(20'hABCD4);
    tick();
    in_valid = '0;
    chk("t1_out_valid", 32'(out_valid), 32'h10);
    chk("t1_out_data", 32'(od(4)), 32'hABCD4);
    tick();
    chk("t1_drained", 32'(out_valid), 32'h00);
    // five inputs contend for CW
    for (int i = 0; i < NP; i++) put(i, 20'h10000 + 20'(i), 3'd1);
    for (int k = 0; k < NP; k++) begin
      #1;
      chk($sformatf("t2_grant%0d", k), 32'(in_ready), 32'(1 << k));
      q[0].push_back(20'h10000 + 20'(k));
      tick();
      in_valid[k] = 1'b0;
      chk($sformatf("t2_valid%0d", k), 32'(out_valid[0]), 32'd1);
    end
    tick();
    chk("t2_drained", 32'(out_valid), 32'h00);
    // five inputs to five distinct outputs
    for (int i = 0; i < NP; i++) begin
      put(i, 20'h20000 + 20'(i), 3'(i + 1));
      q[i].push_back(20'h20000 + 20'(i));
    end
    #1;
    chk("t3_in_ready", 32'(in_ready), 32'h1F);
    tick();
    in_valid = '0;
    chk("t3_out_valid", 32'(out_valid), 32'h1F);
    tick();
    chk("t3_drained", 32'(out_valid), 32'h00);
    // stalled UP output, then pass-through on drain
    out_ready = 5'b11011;
    put(0, 20'h30000, 3'd3);
    #1;
    chk("t4_first", 32'(in_ready), 32'h01);
    q[2].push_back(20'h30000);
    tick();
    in_valid = '0;
    put(3, 20'h30003, 3'd3);
    #1;
    chk("t4_blocked", 32'(in_ready), 32'h00);
    chk("t4_held_valid", 32'(out_valid[2]), 32'd1);
    tick();
    chk("t4_still_blocked", 32'(in_ready), 32'h00);
    chk("t4_held_data", 32'(od(2)), 32'h30000);
    out_ready = '1;
    #1;
    chk("t4_pass", 32'(in_ready), 32'h08);
    q[2].push_back(20'h30003);
    tick();
    in_valid = '0;
    chk("t4_new_data", 32'(od(2)), 32'h30003);
    chk("t4_new_valid", 32'(out_valid[2]), 32'd1);
    tick();
    chk("t4_drained", 32'(out_valid), 32'h00);
    // invalid targets are dropped
    put(1, 20'h40000, 3'd0);
    #1;
    chk("t5_ready0", 32'(in_ready), 32'h02);
    chk("t5_drop0", 32'(drop_pulse), 32'd1);
    tick();
    put(1, 20'h40001, 3'd7);
    #1;
    chk("t5_ready7", 32'(in_ready), 32'h02);
    chk("t5_drop7", 32'(drop_pulse), 32'd1);
    tick();
    in_valid = '0;
    #1;
    chk("t5_no_drop", 32'(drop_pulse), 32'd0);
    chk("t5_no_valid", 32'(out_valid), 32'h00);
`ifdef HSR_SA_STATS_EN
    chk("t5_drop_count", 32'(drop_count), 32'd2);
`endif
    // reset while streaming
    for (int i = 0; i < 3; i++) begin
      put(i, 20'h50000 + 20'(i), 3'(i + 1));
      q[i].push_back(20'h50000 + 20'(i));
    end
    #1;
    chk("t6_in_ready", 32'(in_ready), 32'h07);
    tick();
    chk("t6_streaming", 32'(out_valid), 32'h07);
    rst = 1'b1;
    #1;
    chk("t6_rst_in_ready", 32'(in_ready), 32'h00);
    tick();
    for (int o = 0; o < NP; o++) q[o].delete();
    rst = 1'b0;
    in_valid = '0;
    chk("t6_out_valid", 32'(out_valid), 32'h00);
    chk("t6_out_data", 32'(out_data == '0), 32'd1);
    put(0, 20'h60000, 3'd1);
    put(4, 20'h60004, 3'd1);
    #1;
    chk("t6_ptr_reset", 32'(in_ready), 32'h01);
    q[0].push_back(20'h60000);
    tick();
    in_valid[0] = 1'b0;
    #1;
    chk("t6_second", 32'(in_ready), 32'h10);
    q[0].push_back(20'h60004);
    tick();
    in_valid = '0;
    repeat (2) tick();
    for (int o = 0; o < NP; o++) chk($sformatf("q_empty%0d", o), 32'(q[o].size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hsr_switch_allocator.md
# hsr_switch_allocator

Per-router switch allocator and output stage for the HSR (hierarchical star-ring) NoC. It takes up to five route-computed flits per cycle, each tagged with a 3-bit target direction, and grants each of the five output directions (CW, CCW, Star UP, Star DOWN, PE) to one requester by independent round-robin. The granted flit is registered into a one-deep output buffer with a valid/ready handshake. The block sits directly downstream of the route-compute stages of a leaf, hub or super-hub router and upstream of the link drivers.

## Interface
- `N_PORT`, 5: number of input ports and output directions; fixed at 5 for HSR.
- `DATA_W`, 20: flit width without routing tag, `{payload[15:0], dest_cluster[1:0], dest_local[1:0]}`.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_flit` input N_PORT×(DATA_W+3): per input port, `{data[19:0], target[2:0]}`. Port i occupies bits `[(i+1)*23-1 : i*23]`.
- `in_valid` input N_PORT: per-port flit valid.
- `in_ready` output N_PORT: per-port flit consumed this cycle. Combinational.
- `out_data` output N_PORT×DATA_W: per-direction flit, target stripped. Index o carries direction o+1.
- `out_valid` output N_PORT: per-direction output buffer full.
- `out_ready` input N_PORT: downstream accepts `out_data[o]` this cycle.
- `drop_pulse` output 1: an invalid-target flit was discarded this cycle. Combinational.
- `drop_count` output 16: saturating count of discarded flits. Present only with `HSR_SA_STATS_EN`.

## Operation
- Target decode:
  - targets 1..5 map to output index 0..4 (CW, CCW, UP, DOWN, PE).
  - targets 0, 6 and 7 are invalid.
- An invalid-target flit is accepted immediately: `in_ready[i]`=1 and `drop_pulse`=1. It is never forwarded.
- Request: input i requests output o when `in_valid[i]` is high and its target decodes to o. Each input requests at most one output.
- Output o is grantable when `!out_valid[o] || out_ready[o]`. Pass-through on drain is allowed.
- Per output, one round-robin arbiter with pointer `ptr[o]` (0..4):
  - the search starts at index `ptr[o]` and wraps modulo N_PORT;
  - the first requester found wins.
- On a grant to winner w:
  - `in_ready[w]`=1;
  - `out_data[o]` loads `in_flit[w][22:3]` at the clock edge;
  - `out_valid[o]` is set;
  - `ptr[o]` becomes (w+1) mod 5.
- If output o is not grantable, or has no requester, `ptr[o]` does not change.
- When `out_ready[o]`=1 with no new grant, `out_valid[o]` clears and `out_data[o]` holds its value.
- U-turns (input i to output i) are legal and are not filtered.
- Losing inputs keep `in_valid` high and hold `in_flit` stable until `in_ready` (upstream rule). The allocator makes no assumption beyond this.
- Leaf routers never generate target 4. If one arrives, it is forwarded like any other valid target.

## Timing
- Latency from input grant to `out_valid` is one cycle. Throughput is one flit per output per cycle under continuous `out_ready`.
- `in_ready` depends combinationally on `in_valid`, `in_flit` target, `out_valid` and `out_ready`. No combinational path runs from `in_*` to `out_*`.
- Reset, applied at any cycle including mid-transfer, takes effect at the next edge:
  - `out_valid`=0, `out_data`=0, all `ptr`=0, `drop_count`=0;
  - in-flight buffered flits are lost;
  - while `rst` is high, `in_ready`=0 and `drop_pulse`=0.
- Simultaneous events:
  - Five inputs targeting one output: exactly one grant per cycle. Under continuous demand, all five are served within 5 cycles.
  - Five inputs targeting five distinct grantable outputs: all five are granted in the same cycle.
  - A drain and a new grant on the same output in one cycle: the buffer stays valid with the new flit, and the old flit counts as delivered.
- `drop_count` saturates at 16'hFFFF.

## Configuration
- `HSR_SA_STATS_EN` defined:
  - the `drop_count` port and its 16-bit saturating counter exist;
  - the counter increments by the number of invalid flits dropped that cycle (0..5), clamped at the maximum.
- Not defined:
  - the port and the counter are absent;
  - `drop_pulse` remains;
  - all other behaviour is identical.

## Structure
- Shared package `hsr_noc_pkg` holds:
  - direction constants DIR_CW=1, DIR_CCW=2, DIR_UP=3, DIR_DOWN=4, DIR_PE=5;
  - FLIT_W=20, TAG_W=3, N_PORT=5;
  - the target-to-index decode function.
- Sub-module `hsr_rr_arbiter`:
  - one 5-way round-robin arbiter: request vector, pointer and enable in; one-hot grant out; pointer update registered internally;
  - instantiated once per output direction.

## Test plan
- Reset, then single flit `data=20'hABCD_4`, target 5, on input 0 with `out_ready`=1 -> `in_ready[0]`=1 in the same cycle; one cycle later `out_valid[4]`=1 and `out_data[4]`=20'hABCD4.
- All five inputs hold target 1 with `out_ready[0]`=1 -> grants go to inputs 0,1,2,3,4 in that order, one per cycle; `out_valid[0]` stays high for 5 cycles.
- Inputs 0..4 carry targets 1..5 respectively -> all `in_ready`=1 in one cycle; all `out_valid` are set on the next cycle.
- Output 2 holds a flit with `out_ready[2]`=0 and input 3 requests target 3 -> `in_ready[3]` stays 0 and `out_data[2]` is unchanged. When `out_ready[2]` rises -> `in_ready[3]`=1 in that same cycle (pass-through).
- Input 1 sends target 0, then target 7 -> `in_ready[1]`=1 and `drop_pulse`=1 on each; no `out_valid` rises. With `HSR_SA_STATS_EN`, `drop_count`=2.
- `rst` asserted for one cycle while three outputs are valid and streaming -> all `out_valid`=0 after the edge. The next contention for output 0 grants the lowest requesting index, because all pointers are back at 0.
